twiddle_cmult_pipe: RTL and testbench

- Parametrised, pipelined complex twiddle multiplier for the radix-2 FFT datapath.
- Multiplies a complex sample by W_N^k = cos(2πk/N) − j·sin(2πk/N) (conjugate in inverse mode), with k supplied per sample.
- Generalised successor of the fixed two-constant multiplier block: it adds a full coefficient ROM, a valid/ready handshake, rounding, saturation and an IFFT mode.
- Sits between butterfly stages.

---
 rtl/twiddle_cmult_pipe.sv | 171 +++++++++++++++++
 tb/tb_twiddle_cmult_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_cmult_pipe.sv
// Pipelined complex multiply by W_N^k = cos - j*sin (conjugate when inverting),
// with valid/ready flow control, round-half-up and saturation to OUT_W.
module twiddle_cmult_pipe #(
    parameter int N         = 64,
    parameter int DATA_W    = 16,
    parameter int COEF_FRAC = 16,
    parameter int COEF_W    = COEF_FRAC + 2,
    parameter int OUT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_re,
    input  logic signed [DATA_W-1:0]  in_im,
    input  logic [$clog2(N)-2:0]      in_k,
    input  logic                      in_inv,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_re,
    output logic signed [OUT_W-1:0]   out_im,
    output logic                      ovf
);
    localparam int KW = $clog2(N) - 1;
    localparam int QN = N / 4;
    localparam int IW = $clog2(QN + 1);
    localparam int PW = DATA_W + COEF_W;
    localparam int SW = PW + 1;
    localparam logic [KW-1:0]        QK   = KW'(QN);
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (COEF_FRAC - 1));
    localparam logic signed [SW-1:0] OMAX = SW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SW-1:0] OMIN = -SW'(2 ** (OUT_W - 1));

    function automatic logic signed [COEF_W-1:0] cos_q(input int j);
        real x;
        x = $cos(2.0 * 3.14159265358979323846 * j / N) * (2.0 ** COEF_FRAC);
        return COEF_W'($rtoi($floor(x + 0.5)));
    endfunction

    // Returns {clamped, value}.
    function automatic logic [OUT_W:0] rnd_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        logic [OUT_W:0]       res;
        r = (v + HALF) >>> COEF_FRAC;
        if (r > OMAX) begin
            res = {1'b1, OMAX[OUT_W-1:0]};
        end else if (r < OMIN) begin
            res = {1'b1, OMIN[OUT_W-1:0]};
        end else begin
            res = {1'b0, r[OUT_W-1:0]};
        end
        return res;
    endfunction

    // Quarter-wave cosine table, entries 0..N/4, fixed at elaboration.
    logic signed [COEF_W-1:0] rom [QN+1];
    for (genvar g = 0; g <= QN; g++) begin : g_rom
        localparam logic signed [COEF_W-1:0] CV = cos_q(g);
        assign rom[g] = CV;
    end

    logic                     stall;
    logic [KW-1:0]            m_k;
    logic [IW-1:0]            c_idx, s_idx;
    logic                     c_neg;
    logic signed [COEF_W-1:0] c_dec, s_dec;

    logic                     vld_p1_q, vld_p2_q, vld_p3_q, vld_p3_d;
    logic signed [DATA_W-1:0] a_p1_q, b_p1_q;
    logic signed [COEF_W-1:0] c_p1_q, s_p1_q;
    logic                     inv_p1_q, inv_p2_q;
    logic signed [PW-1:0]     ac_p2_q, bs_p2_q, bc_p2_q, as_p2_q;
    logic signed [SW-1:0]     sum_re, sum_im;
    logic [OUT_W:0]           rs_re, rs_im;
    logic signed [OUT_W-1:0]  out_re_q, out_re_d, out_im_q, out_im_d;
    logic                     ovf_q, ovf_d;

    assign stall    = vld_p3_q & ~out_ready;
    assign in_ready = ~stall;

    // Second half-period: cos goes negative and the roles of the table ends swap.
    assign m_k = in_k - QK;
    always_comb begin
        if (in_k <= QK) begin
            c_idx = IW'(in_k);
            s_idx = IW'(QK - in_k);
            c_neg = 1'b0;
        end else begin
            c_idx = IW'(QK - m_k);
            s_idx = IW'(m_k);
            c_neg = 1'b1;
        end
    end
    assign c_dec = c_neg ? -rom[c_idx] : rom[c_idx];
    assign s_dec = rom[s_idx];

    // Stage 1: operands and decoded twiddle
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (!stall) begin
            vld_p1_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            a_p1_q   <= in_re;
            b_p1_q   <= in_im;
            c_p1_q   <= c_dec;
            s_p1_q   <= s_dec;
            inv_p1_q <= in_inv;
        end
    end

    // Stage 2: full-width partial products
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
        end else if (!stall) begin
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            ac_p2_q  <= PW'(a_p1_q) * PW'(c_p1_q);
            bs_p2_q  <= PW'(b_p1_q) * PW'(s_p1_q);
            bc_p2_q  <= PW'(b_p1_q) * PW'(c_p1_q);
            as_p2_q  <= PW'(a_p1_q) * PW'(s_p1_q);
            inv_p2_q <= inv_p1_q;
        end
    end

    // Stage 3: combine, round, saturate
    assign sum_re = inv_p2_q ? (SW'(ac_p2_q) - SW'(bs_p2_q)) : (SW'(ac_p2_q) + SW'(bs_p2_q));
    assign sum_im = inv_p2_q ? (SW'(bc_p2_q) + SW'(as_p2_q)) : (SW'(bc_p2_q) - SW'(as_p2_q));
    assign rs_re  = rnd_sat(sum_re);
    assign rs_im  = rnd_sat(sum_im);

    always_comb begin
        vld_p3_d = stall ? vld_p3_q : vld_p2_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        ovf_d    = ovf_q;
        if (vld_p2_q && !stall) begin
            out_re_d = rs_re[OUT_W-1:0];
            out_im_d = rs_im[OUT_W-1:0];
            ovf_d    = ovf_q | rs_re[OUT_W] | rs_im[OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p3_q <= 1'b0;
            out_re_q <= '0;
            out_im_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            vld_p3_q <= vld_p3_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = vld_p3_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_twiddle_cmult_pipe.sv
// Scoreboard bench for twiddle_cmult_pipe: randomized and directed samples are
// modelled as a plain complex product with the (conjugated) twiddle.
module tb_twiddle_cmult_pipe;
    localparam int N         = 64;
    localparam int DATA_W    = 16;
    localparam int COEF_FRAC = 16;
    localparam int OUT_W     = 16;
    localparam int KW        = $clog2(N) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re, in_im;
    logic [KW-1:0]            in_k;
    logic                     in_inv;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_re, out_im;
    logic                     ovf;

    twiddle_cmult_pipe #(
        .N(N), .DATA_W(DATA_W), .COEF_FRAC(COEF_FRAC), .COEF_W(COEF_FRAC + 2), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_k(in_k), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
        bit     clamp;
        int     acc_cyc;
        int     stall_at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   n_out = 0;
    bit   exp_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint rhu(input real x);
        if (x >= 0.0) return longint'($floor(x + 0.5));
        return -longint'($floor(-x + 0.5));
    endfunction

    function automatic longint scale(input longint v);
        return (v + (longint'(1) <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
    endfunction

    // (a + jb) * (c - j*s); inverse mode conjugates the twiddle, i.e. flips s.
    function automatic exp_t model(input int a, input int b, input int k, input bit inv);
        exp_t   e;
        real    ang;
        longint c, s, r, i, hi, lo;
        ang = 2.0 * 3.14159265358979323846 * k / N;
        c = rhu($cos(ang) * (2.0 ** COEF_FRAC));
        s = rhu($sin(ang) * (2.0 ** COEF_FRAC));
        if (inv) s = -s;
        r  = scale(a * c + b * s);
        i  = scale(b * c - a * s);
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        e.clamp = 1'b0;
        if (r > hi) begin r = hi; e.clamp = 1'b1; end
        if (r < lo) begin r = lo; e.clamp = 1'b1; end
        if (i > hi) begin i = hi; e.clamp = 1'b1; end
        if (i < lo) begin i = lo; e.clamp = 1'b1; end
        e.re = r;
        e.im = i;
        e.acc_cyc  = 0;
        e.stall_at = 0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the sample is taken.
    task automatic send(input int a, input int b, input int k, input bit inv);
        exp_t e;
        int   waited;
        e = model(a, b, k, inv);
        waited = 0;
        in_valid = 1'b1;
        in_re    = DATA_W'(a);
        in_im    = DATA_W'(b);
        in_k     = KW'(k);
        in_inv   = inv;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1 && !rst) begin
                e.acc_cyc  = cyc;
                e.stall_at = stall_cnt;
                exp_q.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_ready_timeout: in_ready stayed %b, required 1", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, N / 2 - 1)), bit'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compares every output transfer that the coming edge will complete.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else if (out_valid === 1'b1) begin
            if (out_ready !== 1'b1) begin
                stall_cnt++;
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_output: got (%0d,%0d), required no output", out_re, out_im);
            end else begin
                mon_e = exp_q.pop_front();
                exp_ovf = exp_ovf | mon_e.clamp;
                chk("out_re", out_re, mon_e.re);
                chk("out_im", out_im, mon_e.im);
                chk("ovf", ovf, exp_ovf);
                if (mon_e.stall_at == stall_cnt) chk("latency", cyc - mon_e.acc_cyc, 3);
                n_out++;
            end
        end
    end

    int c0, o0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_k = '0; in_inv = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed twiddles: identity, -j, its conjugate, 45 and 135 degrees
        send(1000, -2000, 0, 1'b0);
        send(1000, 2000, 16, 1'b0);
        send(1000, 2000, 16, 1'b1);
        send(16384, 0, 8, 1'b0);
        send(16384, 0, 24, 1'b0);
        send(-300, 777, 31, 1'b1);
        drain();
        @(negedge clk);
        chk("ovf_no_clamp", ovf, 0);
        @(posedge clk); #1;

        // Saturation and stickiness
        send(-32768, -32768, 8, 1'b0);
        send(100, 200, 3, 1'b0);
        send(-50, 7, 20, 1'b1);
        drain();
        @(negedge clk);
        chk("ovf_sticky", ovf, 1);
        @(posedge clk); #1;

        // Full-rate random stream
        c0 = cyc;
        o0 = n_out;
        for (int i = 0; i < 100; i++) send_rand();
        chk("stream_accept_cycles", cyc - c0, 100);
        drain();
        chk("stream_outputs", n_out - o0, 100);

        // Five-cycle output stall while streaming
        out_ready = 1'b0;
        o0 = n_out;
        fork
            for (int i = 0; i < 10; i++) send_rand();
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (out_valid !== 1'b1 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                for (int j = 0; j < 5; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    if (exp_q.size() > 0) begin
                        chk("stall_hold_re", out_re, exp_q[0].re);
                        chk("stall_hold_im", out_im, exp_q[0].im);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_outputs", n_out - o0, 10);

        // Random backpressure
        o0 = n_out;
        fork
            for (int i = 0; i < 60; i++) send_rand();
            begin
                repeat (120) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        chk("bp_outputs", n_out - o0, 60);

        // Reset with samples in flight, then a fresh sample
        send(-32768, -32768, 8, 1'b0);
        send_rand();
        send_rand();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_re", out_re, 0);
        chk("midrst_out_im", out_im, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        o0 = n_out;
        send(1234, -4321, 5, 1'b0);
        drain();
        chk("post_rst_outputs", n_out - o0, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
